convolver_mc: RTL

CONVOLVER_MC -- requirements
Module: convolver_mc

---
 rtl/convolver_mc.sv | 105 ++++++++++
 1 files changed

// File: rtl/convolver_mc.sv
// Multi-channel 2D convolver: streams raster pixels through per-channel line buffers and
// emits one saturated fixed-point result per completed stride-aligned window, 1 cycle after its last pixel.
module convolver_mc #(
  parameter int N = 16,
  parameter int Q = 12,
  parameter int n = 4,
  parameter int k = 3,
  parameter int s = 1,
  parameter int C = 2
) (
  input  logic               clk,
  input  logic               global_rst,
  input  logic               ce,
  input  logic [C*N-1:0]     activation,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [C*k*k*N-1:0] weight,
  input  logic [N-1:0]       bias,
  input  logic               relu_en,
  output logic [N-1:0]       conv_op,
  output logic               valid_conv,
  input  logic               out_ready,
  output logic               end_conv
);
  localparam int L    = (k-1)*n + k;
  localparam int TAPS = C*k*k;
  localparam int ACC  = 2*N + $clog2(TAPS+1) + 1;
  localparam int CW   = $clog2(n);
  localparam int LAST = ((n-k)/s)*s + k - 1;
  localparam logic signed [ACC-1:0] SMAX = {{(ACC-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC-1:0] SMIN = {{(ACC-N+1){1'b1}}, {(N-1){1'b0}}};

  logic [N-1:0] lbuf [C][L];
  logic [N-1:0] nbuf [C][L];
  logic [CW-1:0] row, col;
  logic accept, win, last;
  logic [N-1:0] ta, tw;
  logic signed [2*N-1:0] prod;
  logic signed [ACC-1:0] acc, shifted;
  logic [N-1:0] result;

  assign in_ready = ce && !(valid_conv && !out_ready);
  assign accept   = in_valid && in_ready;
  assign win  = (int'(row) >= k-1) && (int'(col) >= k-1) &&
                ((int'(row)-k+1) % s == 0) && ((int'(col)-k+1) % s == 0);
  assign last = (int'(row) == LAST) && (int'(col) == LAST);

  // The window is evaluated on the buffer contents as they will be after this pixel shifts in.
  always_comb begin
    for (int c = 0; c < C; c++) begin
      nbuf[c][0] = activation[c*N +: N];
      for (int i = 1; i < L; i++) nbuf[c][i] = lbuf[c][i-1];
    end
  end

  always_comb begin
    ta   = '0;
    tw   = '0;
    prod = '0;
    acc  = {{(ACC-N-Q){bias[N-1]}}, bias, {Q{1'b0}}};
    for (int c = 0; c < C; c++)
      for (int r = 0; r < k; r++)
        for (int q = 0; q < k; q++) begin
          ta   = nbuf[c][(k-1-r)*n + (k-1-q)];
          tw   = weight[((c*k+r)*k+q)*N +: N];
          prod = $signed({{N{ta[N-1]}}, ta}) * $signed({{N{tw[N-1]}}, tw});
          acc  = acc + {{(ACC-2*N){prod[2*N-1]}}, prod};
        end
    shifted = acc >>> Q;
    if (shifted > SMAX)      result = {1'b0, {(N-1){1'b1}}};
    else if (shifted < SMIN) result = {1'b1, {(N-1){1'b0}}};
    else                     result = shifted[N-1:0];
    if (relu_en && result[N-1]) result = '0;
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      row        <= '0;
      col        <= '0;
      conv_op    <= '0;
      valid_conv <= 1'b0;
      end_conv   <= 1'b0;
      for (int c = 0; c < C; c++)
        for (int i = 0; i < L; i++) lbuf[c][i] <= '0;
    end else if (ce) begin
      if (accept) begin
        lbuf <= nbuf;
        if (int'(col) == n-1) begin
          col <= '0;
          row <= (int'(row) == n-1) ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (accept && win) begin
        conv_op    <= result;
        valid_conv <= 1'b1;
        end_conv   <= last;
      end else if (out_ready) begin
        valid_conv <= 1'b0;
        end_conv   <= 1'b0;
      end
    end
  end
endmodule
